bcd_tick_counter: RTL and testbench
===================================

// Module: bcd_tick_counter
// PURPOSE
//  Downstream consumer of the clock divider's divided_clk square wave. Samples divided_clk in
//  the fast clk_in domain through a synchronizer and converts each rising edge into a one-cycle
//  tick. Counts ticks in a NUM_DIGITS-digit packed BCD up/down counter with clear, load and
//  wrap flag. Feeds the display/readout stage with a stable BCD value.
// PARAMETERS
//  NUM_DIGITS   4   BCD digits in count; count width = 4*NUM_DIGITS
//  SYNC_STAGES  2   synchronizer flops on divided_clk (legal range 2..4)
// PORTS
//  clk_in       in   1             system clock; only clock in the block
//  rst_n        in   1             synchronous, active-low reset
//  divided_clk  in   1             slow square wave from clock divider; treated as asynchronous
//  en           in   1             1 = count ticks; 0 = hold count (tick still reported)
//  up_dn        in   1             1 = count up, 0 = count down; sampled on tick cycle
//  clr          in   1             synchronous clear of count
//  load         in   1             synchronous load of load_value
//  load_value   in   4*NUM_DIGITS  packed BCD, digit 0 in [3:0]
//  count_bcd    out  4*NUM_DIGITS  registered packed BCD count, digit 0 in [3:0]
//  tick         out  1             registered 1-cycle pulse per detected divided_clk rising edge
//  wrap         out  1             registered 1-cycle pulse on roll-over/roll-under
// BEHAVIOUR
//  - Reset (rst_n=0 at clk_in edge): count_bcd=0, tick=0, wrap=0, sync chain=0, edge-prev=0.
//    Reset mid-operation takes effect at the next edge; any in-flight tick is discarded.
//  - Sync/edge: divided_clk passes through SYNC_STAGES flops. rise = last stage & ~prev.
//    tick registers rise. Latency: from the edge that first samples divided_clk=1 to tick=1
//    and count update is exactly SYNC_STAGES+1 clk_in edges (3 with default).
//  - Reset state is low, so divided_clk high at reset release yields one tick, by design.
//  - A divided_clk high or low phase shorter than 1 clk_in period may be missed; no error flag.
//  - Count update priority per clk_in edge: clr > load > (rise & en) > hold.
//  - clr=1: count=0, wrap=0. A coincident rise still sets tick=1 but does not count.
//  - load=1: count=load_value. Any nibble > 9 is stored as 9. No wrap. A coincident rise is
//    not counted.
//  - rise & en & up_dn: add 1 with BCD carry across digits. At all-9s, count goes to 0 and
//    wrap=1 for one cycle.
//  - rise & en & ~up_dn: subtract 1 with BCD borrow. At 0, count goes to all-9s and wrap=1.
//  - en=0: count holds and wrap stays 0. tick still pulses.
//  - wrap and tick are high only in the cycle after the causing edge; neither is ever high
//    two consecutive cycles.
//  - count_bcd is always valid BCD (every nibble 0..9) in every cycle.
// STRUCTURE
//  - Shared package bcd_pkg holds:
//    - BCD_DIGIT_W=4 and BCD_MAX=4'd9;
//    - functions bcd_inc_digit/bcd_dec_digit, each returning {carry, digit};
//    - function bcd_sat_digit for clamping >9 to 9.
//  - One sub-module, sync_rise_detect (param STAGES). Inputs: clk_in, rst_n, async_in.
//    Output: rise, combinational from registered state.
//  - Top holds the counter datapath, a digit-generate loop for the carry/borrow chain, and the
//    tick/wrap output registers.
// TESTING
//  1 Reset: hold rst_n=0 with divided_clk toggling -> count_bcd=0, tick=0, wrap=0 throughout.
//  2 Latency: divided_clk 0->1 with en=1, up_dn=1, count=0 -> tick=1 and count=0001 exactly
//    3 clk_in edges later; tick low the following cycle.
//  3 Wrap up/down: load 9999, one rise, up_dn=1 -> 0000 and wrap=1 for 1 cycle. Then up_dn=0,
//    one rise -> 9999 and wrap=1.
//  4 Digit carry: load 0199, rise, up -> 0200. Load 1000, rise, down -> 0999. wrap=0 for both.
//  5 Priority: clr and load asserted in the same cycle as a rise -> count=0 and tick=1.
//    Load 12F4 -> count=1294.
//  6 Enable and mid-reset: en=0 over 5 rises -> count unchanged, 5 tick pulses. rst_n=0 for
//    1 cycle while a rise is in the sync chain -> no tick, count=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit constants and per-digit arithmetic helpers
package bcd_pkg;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX     = 4'd9;

    // Returns {carry_out, digit}; carry_out set when a carry-in rolls 9 over to 0.
    function automatic logic [4:0] bcd_inc_digit(input logic [3:0] d, input logic cin);
        logic [4:0] r;
        if (!cin) begin
            r = {1'b0, d};
        end else if (d >= BCD_MAX) begin
            r = {1'b1, 4'd0};
        end else begin
            r = {1'b0, d + 4'd1};
        end
        return r;
    endfunction

    // Returns {borrow_out, digit}; borrow_out set when a borrow-in rolls 0 under to 9.
    function automatic logic [4:0] bcd_dec_digit(input logic [3:0] d, input logic bin);
        logic [4:0] r;
        if (!bin) begin
            r = {1'b0, d};
        end else if (d == 4'd0) begin
            r = {1'b1, BCD_MAX};
        end else begin
            r = {1'b0, d - 4'd1};
        end
        return r;
    endfunction

    function automatic logic [3:0] bcd_sat_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// rtl/sync_rise_detect.sv - multi-flop synchronizer with rising-edge detect
module sync_rise_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/bcd_tick_counter.sv
// rtl/bcd_tick_counter.sv - BCD up/down counter of synchronized divided_clk rising edges
module bcd_tick_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          divided_clk,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          clr,
    input  logic                          load,
    input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] load_value,
    output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] count_bcd,
    output logic                          tick,
    output logic                          wrap
);

    localparam int W = BCD_DIGIT_W * NUM_DIGITS;

    logic            rise;
    logic [W-1:0]    count_q, count_d;
    logic            tick_q;
    logic            wrap_q, wrap_d;
    logic [W-1:0]    inc_val, dec_val, sat_val;
    logic [NUM_DIGITS-1:0] is9, is0, cin_up, bin_dn, inc_co, dec_co;

    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .async_in (divided_clk),
        .rise     (rise)
    );

    // Carry/borrow into each digit is a lookahead over the lower digits, not a ripple.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign is9[i] = (count_q[BCD_DIGIT_W*i +: BCD_DIGIT_W] == BCD_MAX);
        assign is0[i] = (count_q[BCD_DIGIT_W*i +: BCD_DIGIT_W] == 4'd0);
        if (i == 0) begin : g_lsd
            assign cin_up[i] = 1'b1;
            assign bin_dn[i] = 1'b1;
        end else begin : g_upper
            assign cin_up[i] = &is9[i-1:0];
            assign bin_dn[i] = &is0[i-1:0];
        end
        assign {inc_co[i], inc_val[BCD_DIGIT_W*i +: BCD_DIGIT_W]} =
            bcd_inc_digit(count_q[BCD_DIGIT_W*i +: BCD_DIGIT_W], cin_up[i]);
        assign {dec_co[i], dec_val[BCD_DIGIT_W*i +: BCD_DIGIT_W]} =
            bcd_dec_digit(count_q[BCD_DIGIT_W*i +: BCD_DIGIT_W], bin_dn[i]);
        assign sat_val[BCD_DIGIT_W*i +: BCD_DIGIT_W] =
            bcd_sat_digit(load_value[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
    end

    // The count rolls over only when every digit carries (or borrows) out.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = sat_val;
        end else if (rise && en) begin
            if (up_dn) begin
                count_d = inc_val;
                wrap_d  = &inc_co;
            end else begin
                count_d = dec_val;
                wrap_d  = &dec_co;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= rise;
            wrap_q  <= wrap_d;
        end
    end

    assign count_bcd = count_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb/tb_bcd_tick_counter.sv - directed self-checking bench for bcd_tick_counter
module tb_bcd_tick_counter;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        divided_clk;
    logic        en;
    logic        up_dn;
    logic        clr;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count_bcd;
    logic        tick;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    bcd_tick_counter #(.NUM_DIGITS(4), .SYNC_STAGES(2)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .divided_clk (divided_clk),
        .en          (en),
        .up_dn       (up_dn),
        .clr         (clr),
        .load        (load),
        .load_value  (load_value),
        .count_bcd   (count_bcd),
        .tick        (tick),
        .wrap        (wrap)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_value = v;
        step();
        load = 1'b0;
    endtask

    // One divided_clk pulse; tick/wrap/count appear on the third edge, then the chain settles low.
    task automatic rise_chk(input string tag, input logic [15:0] exp_cnt, input logic exp_wrap);
        divided_clk = 1'b1;
        step();
        chk({tag, "_tick_early"}, tick, 1'b0);
        step();
        step();
        chk({tag, "_tick"}, tick, 1'b1);
        chk({tag, "_count"}, count_bcd, exp_cnt);
        chk({tag, "_wrap"}, wrap, exp_wrap);
        divided_clk = 1'b0;
        step();
        chk({tag, "_tick_after"}, tick, 1'b0);
        chk({tag, "_wrap_after"}, wrap, 1'b0);
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0; divided_clk = 1'b0; en = 1'b1; up_dn = 1'b1;
        clr = 1'b0; load = 1'b0; load_value = 16'h0000;

        // Reset held while divided_clk toggles
        for (int i = 0; i < 6; i++) begin
            divided_clk = ~divided_clk;
            step();
            chk("rst_count", count_bcd, 16'h0000);
            chk("rst_tick", tick, 1'b0);
            chk("rst_wrap", wrap, 1'b0);
        end
        divided_clk = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("post_rst_tick", tick, 1'b0);

        // Latency: three edges from first sample to tick and count
        rise_chk("latency", 16'h0001, 1'b0);

        // Wrap up and down
        do_load(16'h9999);
        chk("load_9999", count_bcd, 16'h9999);
        rise_chk("wrap_up", 16'h0000, 1'b1);
        up_dn = 1'b0;
        rise_chk("wrap_dn", 16'h9999, 1'b1);

        // Digit carry and borrow
        up_dn = 1'b1;
        do_load(16'h0199);
        rise_chk("carry", 16'h0200, 1'b0);
        up_dn = 1'b0;
        do_load(16'h1000);
        rise_chk("borrow", 16'h0999, 1'b0);
        up_dn = 1'b1;

        // clr and load coincident with a rise: clr wins, tick still reported
        do_load(16'h4321);
        divided_clk = 1'b1;
        step(); step();
        clr = 1'b1; load = 1'b1; load_value = 16'h5555;
        step();
        clr = 1'b0; load = 1'b0;
        chk("prio_clr_count", count_bcd, 16'h0000);
        chk("prio_clr_tick", tick, 1'b1);
        chk("prio_clr_wrap", wrap, 1'b0);
        divided_clk = 1'b0;
        step(); step(); step();

        // load coincident with a rise: rise not counted
        divided_clk = 1'b1;
        step(); step();
        load = 1'b1; load_value = 16'h0456;
        step();
        load = 1'b0;
        chk("prio_load_count", count_bcd, 16'h0456);
        chk("prio_load_tick", tick, 1'b1);
        divided_clk = 1'b0;
        step(); step(); step();

        // Saturating load of a non-BCD nibble
        do_load(16'h12F4);
        chk("load_sat", count_bcd, 16'h1294);
        do_load(16'hABCD);
        chk("load_sat_all", count_bcd, 16'h9999);

        // en=0: five ticks, count holds
        do_load(16'h0042);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rise_chk("hold", 16'h0042, 1'b0);
        end
        en = 1'b1;

        // Reset while a rise is in the sync chain discards it
        do_load(16'h0777);
        divided_clk = 1'b1;
        step();
        divided_clk = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_count", count_bcd, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst_tick", tick, 1'b0);
        end
        chk("midrst_count_end", count_bcd, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
